// File: rtl/lp_fltr_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// lp_fltr_pkg : shared constants and pipe-stage type for lp_fltr_sched
// Rev 1.0
// ------------------------------------------------------------------
package lp_fltr_pkg;

   localparam int DEF_DW  = 8;
   localparam int DEF_NCH = 4;
   localparam int CHW     = $clog2(DEF_NCH);
   localparam int LAT     = 3;
   localparam int XW      = DEF_DW + 2;

   // a carries x0, then p, then sum; b carries x1, then q; c carries x2
   typedef struct packed {
      logic                 valid;
      logic [CHW-1:0]       chan;
      logic signed [XW-1:0] a;
      logic signed [XW-1:0] b;
      logic signed [XW-1:0] c;
   } pipe_t;

   function automatic logic signed [XW-1:0] sext(input logic [DEF_DW-1:0] v);
      return {{(XW-DEF_DW){v[DEF_DW-1]}}, v};
   endfunction

endpackage
`default_nettype wire

// File: rtl/lp_fltr_sched_arb.sv
`default_nettype none
// ------------------------------------------------------------------
// lp_rr_arb : NCH-wide round-robin arbiter with one-hot grant
// Rev 1.0
// ------------------------------------------------------------------
module lp_rr_arb #(
   parameter  int NCH = 4,
   localparam int CW  = $clog2(NCH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] req,
   input  logic           en,
   output logic [NCH-1:0] gnt,
   output logic [CW-1:0]  gnt_idx,
   output logic           gnt_any
);

   logic [CW-1:0] ptr_q, ptr_d;
   logic [CW:0]   cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      // scan cyclically from ptr; first requester wins
      for (int off = 0; off < NCH; off++) begin
         cand = {1'b0, ptr_q} + (CW+1)'(off);
         if (cand >= (CW+1)'(NCH)) cand = cand - (CW+1)'(NCH);
         if (en && !gnt_any && req[cand[CW-1:0]]) begin
            gnt[cand[CW-1:0]] = 1'b1;
            gnt_idx           = cand[CW-1:0];
            gnt_any           = 1'b1;
         end
      end
      ptr_d = ptr_q;
      if (gnt_any) ptr_d = (gnt_idx == CW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule
`default_nettype wire

// File: rtl/lp_fltr_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// lp_fltr_sched : round-robin scheduled [1 2 1]/4 low-pass filter
// Rev 1.0
// ------------------------------------------------------------------
module lp_fltr_sched
   import lp_fltr_pkg::*;
#(
   parameter  int DW  = DEF_DW,
   parameter  int NCH = DEF_NCH,
   localparam int CW  = $clog2(NCH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NCH-1:0]    s_valid,
   input  logic [NCH*DW-1:0] s_data,
   output logic [NCH-1:0]    s_ready,
   input  logic [NCH-1:0]    ch_clr,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [CW-1:0]     m_chan,
   output logic [DW-1:0]     m_data
);

   logic           stall;
   logic [NCH-1:0] gnt;
   logic [CW-1:0]  gnt_idx;
   logic           gnt_any;

   logic [DW-1:0]  h1_q [NCH];
   logic [DW-1:0]  h1_d [NCH];
   logic [DW-1:0]  h2_q [NCH];
   logic [DW-1:0]  h2_d [NCH];
   logic [DW-1:0]  x0, x1, x2;

   pipe_t          s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
   logic           m_valid_q, m_valid_d;
   logic [CW-1:0]  m_chan_q, m_chan_d;
   logic [DW-1:0]  m_data_q, m_data_d;
   logic           unused_bits;

   assign stall = m_valid_q & ~m_ready;

   lp_rr_arb #(.NCH(NCH)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (s_valid),
      .en      (!stall && !rst),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   assign s_ready = gnt;

   always_comb begin
      h1_d = h1_q;
      h2_d = h2_q;
      // clears land before the accepted sample reads its taps
      for (int i = 0; i < NCH; i++) begin
         if (ch_clr[i]) begin
            h1_d[i] = '0;
            h2_d[i] = '0;
         end
      end
      x0 = s_data[gnt_idx*DW +: DW];
      x1 = h1_d[gnt_idx];
      x2 = h2_d[gnt_idx];
      if (gnt_any) begin
         h2_d[gnt_idx] = x1;
         h1_d[gnt_idx] = x0;
      end

      s0_d      = s0_q;
      s1_d      = s1_q;
      s2_d      = s2_q;
      m_valid_d = m_valid_q;
      m_chan_d  = m_chan_q;
      m_data_d  = m_data_q;
      if (!stall) begin
         s0_d.valid = gnt_any;
         s0_d.chan  = gnt_idx;
         s0_d.a     = sext(x0);
         s0_d.b     = sext(x1);
         s0_d.c     = sext(x2);

         s1_d.valid = s0_q.valid;
         s1_d.chan  = s0_q.chan;
         s1_d.a     = s0_q.a + s0_q.c;
         s1_d.b     = s0_q.b <<< 1;
         s1_d.c     = '0;

         s2_d.valid = s1_q.valid;
         s2_d.chan  = s1_q.chan;
         s2_d.a     = s1_q.a + s1_q.b;
         s2_d.b     = '0;
         s2_d.c     = '0;

         m_valid_d = s2_q.valid;
         if (s2_q.valid) begin
            m_chan_d = s2_q.chan;
            m_data_d = s2_q.a[DW+1:2];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            h1_q[i] <= '0;
            h2_q[i] <= '0;
         end
         s0_q      <= '0;
         s1_q      <= '0;
         s2_q      <= '0;
         m_valid_q <= 1'b0;
         m_chan_q  <= '0;
         m_data_q  <= '0;
      end else begin
         h1_q      <= h1_d;
         h2_q      <= h2_d;
         s0_q      <= s0_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         m_valid_q <= m_valid_d;
         m_chan_q  <= m_chan_d;
         m_data_q  <= m_data_d;
      end
   end

   assign m_valid = m_valid_q;
   assign m_chan  = m_chan_q;
   assign m_data  = m_data_q;

   // fields that are dead past their stage; the low sum bits are the floor-shifted remainder
   assign unused_bits = ^{s1_q.c, s2_q.b, s2_q.c, s2_q.a[1:0]};

endmodule
`default_nettype wire
